// File: rtl/prco_decoder_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | prco_decoder_pipe: valid/ready decode stage with RAW/WAW stall    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module prco_decoder_pipe #(
  parameter int INSTR_W = 16,
  parameter int OP_W    = 5,
  parameter int SEL_W   = 3,
  parameter int IMM_W   = 8,
  parameter int SIMM_W  = 5
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_valid,
  input  logic [INSTR_W-1:0]     i_instr,
  output logic                   o_ready,
  output logic                   q_valid,
  input  logic                   i_ready,
  input  logic                   i_flush,
  input  logic                   i_wb_en,
  input  logic [SEL_W-1:0]       i_wb_sel,
  output logic [OP_W-1:0]        q_op,
  output logic [SEL_W-1:0]       q_seld,
  output logic [SEL_W-1:0]       q_sela,
  output logic [SEL_W-1:0]       q_selb,
  output logic [IMM_W-1:0]       q_imm,
  output logic [SIMM_W-1:0]      q_simm,
  output logic                   q_reg_we,
  output logic                   q_req_alu,
  output logic                   q_req_ram,
  output logic                   q_req_ram_we,
  output logic                   q_new_uart1_data,
  output logic                   q_halt,
  output logic                   o_stall,
  output logic [(2**SEL_W)-1:0]  o_busy
);

  localparam int c_nreg  = 2**SEL_W;
  localparam int c_d_lsb = INSTR_W - OP_W - SEL_W;
  localparam int c_a_lsb = c_d_lsb - SEL_W;
  localparam int c_b_lsb = c_a_lsb - SEL_W;

  localparam logic [c_nreg-1:0] c_one = c_nreg'(1);

  localparam logic [OP_W-1:0] c_op_nop   = OP_W'(0);
  localparam logic [OP_W-1:0] c_op_movi  = OP_W'(1);
  localparam logic [OP_W-1:0] c_op_mov   = OP_W'(2);
  localparam logic [OP_W-1:0] c_op_add   = OP_W'(3);
  localparam logic [OP_W-1:0] c_op_addi  = OP_W'(4);
  localparam logic [OP_W-1:0] c_op_lw    = OP_W'(5);
  localparam logic [OP_W-1:0] c_op_sw    = OP_W'(6);
  localparam logic [OP_W-1:0] c_op_cmp   = OP_W'(7);
  localparam logic [OP_W-1:0] c_op_jmp   = OP_W'(8);
  localparam logic [OP_W-1:0] c_op_write = OP_W'(9);

  logic [OP_W-1:0]   w_op;
  logic [SEL_W-1:0]  w_d;
  logic [SEL_W-1:0]  w_a;
  logic [SEL_W-1:0]  w_b;
  logic              w_we;
  logic              w_alu;
  logic              w_ram;
  logic              w_ram_we;
  logic              w_uart;
  logic              w_known;
  logic              w_src_d;
  logic              w_src_a;
  logic [c_nreg-1:0] w_clr;
  logic [c_nreg-1:0] w_set;
  logic [c_nreg-1:0] w_busy_eff;
  logic              w_inflight;
  logic              w_haz_d;
  logic              w_haz_a;
  logic              w_hazard;
  logic              w_accept;
  logic              w_hs;

  assign w_op = i_instr[INSTR_W-1 -: OP_W];
  assign w_d  = i_instr[c_d_lsb +: SEL_W];
  assign w_a  = i_instr[c_a_lsb +: SEL_W];
  assign w_b  = i_instr[c_b_lsb +: SEL_W];

  always_comb begin
    w_we     = 1'b0;
    w_alu    = 1'b0;
    w_ram    = 1'b0;
    w_ram_we = 1'b0;
    w_uart   = 1'b0;
    w_known  = 1'b1;
    w_src_d  = 1'b0;
    w_src_a  = 1'b0;
    case (w_op)
      c_op_nop:   ;
      c_op_movi:  begin w_we = 1'b1; w_alu = 1'b1; end
      c_op_mov:   begin w_we = 1'b1; w_alu = 1'b1; w_src_a = 1'b1; end
      c_op_add:   begin w_we = 1'b1; w_alu = 1'b1; w_src_d = 1'b1; w_src_a = 1'b1; end
      c_op_addi:  begin w_we = 1'b1; w_alu = 1'b1; w_src_d = 1'b1; end
      c_op_lw:    begin w_we = 1'b1; w_alu = 1'b1; w_ram = 1'b1; w_src_a = 1'b1; end
      c_op_sw:    begin
        w_alu = 1'b1; w_ram = 1'b1; w_ram_we = 1'b1; w_src_d = 1'b1; w_src_a = 1'b1;
      end
      c_op_cmp:   begin w_alu = 1'b1; w_src_d = 1'b1; w_src_a = 1'b1; end
      c_op_jmp:   w_we = 1'b1;
      c_op_write: begin w_uart = 1'b1; w_src_d = 1'b1; end
      default:    w_known = 1'b0;
    endcase
  end

  // A writeback in this cycle releases its register before the hazard check.
  assign w_clr      = i_wb_en ? (c_one << i_wb_sel) : '0;
  assign w_busy_eff = o_busy & ~w_clr;
  assign w_inflight = q_valid & q_reg_we;

  assign w_haz_d  = (w_src_d | w_we) &
                    (w_busy_eff[w_d] | (w_inflight & (q_seld == w_d)));
  assign w_haz_a  = w_src_a &
                    (w_busy_eff[w_a] | (w_inflight & (q_seld == w_a)));
  assign w_hazard = w_haz_d | w_haz_a;

  assign o_stall  = i_valid & w_hazard;
  assign o_ready  = !i_reset & !q_halt & !w_hazard & (!q_valid | i_ready);
  assign w_accept = i_valid & o_ready & !i_flush;
  assign w_hs     = q_valid & i_ready & !i_flush;
  assign w_set    = (w_hs & q_reg_we) ? (c_one << q_seld) : '0;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      q_valid          <= 1'b0;
      q_op             <= '0;
      q_seld           <= '0;
      q_sela           <= '0;
      q_selb           <= '0;
      q_imm            <= '0;
      q_simm           <= '0;
      q_reg_we         <= 1'b0;
      q_req_alu        <= 1'b0;
      q_req_ram        <= 1'b0;
      q_req_ram_we     <= 1'b0;
      q_new_uart1_data <= 1'b0;
      q_halt           <= 1'b0;
      o_busy           <= '0;
    end else begin
      // Set is ORed in after the clear so a same-register set wins.
      o_busy <= (o_busy & ~w_clr) | w_set;
      if (w_accept) begin
        q_valid          <= 1'b1;
        q_op             <= w_op;
        q_seld           <= w_d;
        q_sela           <= w_a;
        q_selb           <= w_b;
        q_imm            <= i_instr[IMM_W-1:0];
        q_simm           <= i_instr[SIMM_W-1:0];
        q_reg_we         <= w_we;
        q_req_alu        <= w_alu;
        q_req_ram        <= w_ram;
        q_req_ram_we     <= w_ram_we;
        q_new_uart1_data <= w_uart;
        q_halt           <= q_halt | !w_known;
      end else if (w_hs || i_flush) begin
        q_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prco_decoder_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_prco_decoder_pipe: directed self-checking bench for decode     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_prco_decoder_pipe;

  localparam logic [4:0] c_nop = 5'd0, c_movi = 5'd1, c_mov = 5'd2, c_add = 5'd3;
  localparam logic [4:0] c_addi = 5'd4, c_lw = 5'd5, c_sw = 5'd6, c_cmp = 5'd7;
  localparam logic [4:0] c_jmp = 5'd8, c_write = 5'd9, c_bad = 5'h1F;

  logic        i_clk = 1'b0;
  logic        i_reset, i_valid, i_ready, i_flush, i_wb_en;
  logic [15:0] i_instr;
  logic [2:0]  i_wb_sel;
  logic        o_ready, q_valid, o_stall;
  logic [4:0]  q_op, q_simm;
  logic [2:0]  q_seld, q_sela, q_selb;
  logic [7:0]  q_imm, o_busy;
  logic        q_reg_we, q_req_alu, q_req_ram, q_req_ram_we, q_new_uart1_data, q_halt;

  int n_checks = 0;
  int n_errors = 0;
  int hi_cnt;

  logic [4:0] t_op  [4] = '{c_sw, c_cmp, c_write, c_jmp};
  logic [4:0] t_flg [4] = '{5'b01110, 5'b01000, 5'b00001, 5'b10000};

  always #5 i_clk = ~i_clk;

  prco_decoder_pipe dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_instr(i_instr),
    .o_ready(o_ready), .q_valid(q_valid), .i_ready(i_ready), .i_flush(i_flush),
    .i_wb_en(i_wb_en), .i_wb_sel(i_wb_sel), .q_op(q_op), .q_seld(q_seld),
    .q_sela(q_sela), .q_selb(q_selb), .q_imm(q_imm), .q_simm(q_simm),
    .q_reg_we(q_reg_we), .q_req_alu(q_req_alu), .q_req_ram(q_req_ram),
    .q_req_ram_we(q_req_ram_we), .q_new_uart1_data(q_new_uart1_data),
    .q_halt(q_halt), .o_stall(o_stall), .o_busy(o_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [15:0] enc_r(logic [4:0] op, logic [2:0] d, logic [2:0] a, logic [2:0] b);
    return {op, d, a, b, 2'b00};
  endfunction

  function automatic logic [15:0] enc_i(logic [4:0] op, logic [2:0] d, logic [7:0] imm);
    return {op, d, imm};
  endfunction

  function automatic logic [4:0] flags();
    return {q_reg_we, q_req_alu, q_req_ram, q_req_ram_we, q_new_uart1_data};
  endfunction

  task automatic wb_clear(input logic [2:0] sel);
    i_wb_en = 1'b1; i_wb_sel = sel;
    tick();
    i_wb_en = 1'b0;
  endtask

  initial begin
    i_reset = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_flush = 1'b0;
    i_wb_en = 1'b0; i_wb_sel = '0; i_instr = '0;
    #1 i_reset = 1'b1;
    #1;
    chk("rst_ready", o_ready, 0);
    chk("rst_valid", q_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_fields", {q_op, q_seld, q_sela, q_selb, q_imm, q_simm, flags(), q_halt}, 0);
    tick(); tick();
    i_reset = 1'b0;

    // MOVI r2, 0x5A
    i_valid = 1'b1; i_instr = enc_i(c_movi, 3'd2, 8'h5A);
    #1 chk("movi_ready", o_ready, 1);
    tick();
    i_valid = 1'b0; i_instr = '0;
    chk("movi_valid", q_valid, 1);
    chk("movi_op_d", {q_op, q_seld}, {c_movi, 3'd2});
    chk("movi_imm", {q_imm, q_simm}, {8'h5A, 5'h1A});
    chk("movi_flags", flags(), 5'b11000);
    tick();
    chk("movi_busy", o_busy, 8'h04);
    chk("movi_drop", q_valid, 0);
    wb_clear(3'd2);
    chk("wb2_busy", o_busy, 8'h00);

    // MOVI r3 then ADD r3,r1 back-to-back
    i_valid = 1'b1; i_instr = enc_i(c_movi, 3'd3, 8'h11);
    tick();
    i_instr = enc_r(c_add, 3'd3, 3'd1, 3'd0);
    #1 chk("raw_stall0", {o_stall, o_ready}, 2'b10);
    tick();
    chk("raw_busy3", o_busy, 8'h08);
    #1 chk("raw_stall1", {o_stall, o_ready}, 2'b10);
    tick();
    chk("raw_noacc", q_valid, 0);
    i_wb_en = 1'b1; i_wb_sel = 3'd3;
    #1 chk("raw_bypass", {o_stall, o_ready}, 2'b01);
    tick();
    i_wb_en = 1'b0; i_valid = 1'b0; i_instr = '0;
    chk("add_fields", {q_valid, q_op, q_seld, q_sela}, {1'b1, c_add, 3'd3, 3'd1});
    chk("add_busy0", o_busy, 8'h00);
    tick();
    chk("add_busy3", o_busy, 8'h08);
    wb_clear(3'd3);

    // Back-pressure: MOV r5,r6 held 3 cycles, ADDI r7 waiting
    i_valid = 1'b1; i_instr = enc_r(c_mov, 3'd5, 3'd6, 3'd0);
    tick();
    i_ready = 1'b0; i_instr = enc_i(c_addi, 3'd7, 8'h03);
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_ready", o_ready, 0);
      tick();
      chk("bp_hold", {q_valid, q_op, q_seld, q_sela, o_busy}, {1'b1, c_mov, 3'd5, 3'd6, 8'h00});
    end
    i_ready = 1'b1;
    #1 chk("bp_release", o_ready, 1);
    tick();
    i_valid = 1'b0; i_instr = '0;
    chk("addi_fields", {q_op, q_seld, q_imm, q_simm}, {c_addi, 3'd7, 8'h03, 5'h03});
    chk("addi_busy5", o_busy, 8'h20);
    tick();
    chk("addi_busy57", o_busy, 8'hA0);
    wb_clear(3'd5);
    wb_clear(3'd7);
    chk("bp_clean", o_busy, 8'h00);

    // Handshake of MOV r5 with writeback of r5 in the same cycle
    i_valid = 1'b1; i_instr = enc_r(c_mov, 3'd5, 3'd6, 3'd0);
    tick();
    i_valid = 1'b0; i_instr = '0; i_wb_en = 1'b1; i_wb_sel = 3'd5;
    tick();
    chk("setwins", o_busy, 8'h20);
    tick();
    i_wb_en = 1'b0;
    chk("setwins_clr", o_busy, 8'h00);

    // Flush while holding LW r4; the MOVI presented alongside is dropped
    i_valid = 1'b1; i_ready = 1'b0; i_instr = enc_r(c_lw, 3'd4, 3'd1, 3'd0);
    tick();
    chk("lw_flags", {q_valid, flags()}, {1'b1, 5'b11100});
    i_flush = 1'b1; i_ready = 1'b1; i_instr = enc_i(c_movi, 3'd6, 8'h22);
    tick();
    i_flush = 1'b0; i_valid = 1'b0; i_instr = '0;
    chk("flush_valid", q_valid, 0);
    chk("flush_busy", o_busy, 8'h00);
    tick();
    chk("flush_noacc", {q_valid, o_busy}, 9'h000);

    // Flag table, one instruction per cycle at full throughput
    i_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_instr = enc_r(t_op[k], 3'd0, 3'd0, 3'd0);
      tick();
      chk("tbl_flags", {q_valid, q_op, flags()}, {1'b1, t_op[k], t_flg[k]});
    end
    i_valid = 1'b0; i_instr = '0;
    tick();
    chk("jmp_busy", o_busy, 8'h01);
    wb_clear(3'd0);

    // Unknown opcode halts decode
    i_valid = 1'b1; i_instr = {c_bad, 11'h000};
    tick();
    chk("bad_halt", {q_valid, q_halt, flags()}, {1'b1, 1'b1, 5'b00000});
    i_instr = enc_i(c_movi, 3'd1, 8'h07);
    tick();
    chk("bad_drop", q_valid, 0);
    hi_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (o_ready) hi_cnt++;
      tick();
    end
    chk("halt_ready_cnt", hi_cnt, 0);
    chk("halt_sticky", {q_halt, q_valid}, 2'b10);
    i_reset = 1'b1;
    #2;
    chk("async_rst", {q_halt, o_ready, q_op}, 7'h00);
    i_reset = 1'b0;
    #1 chk("post_rst_ready", o_ready, 1);
    tick();
    i_valid = 1'b0; i_instr = '0;
    chk("post_rst_acc", {q_valid, q_op, q_seld, q_imm}, {1'b1, c_movi, 3'd1, 8'h07});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prco_decoder_pipe.md
# prco_decoder_pipe

Parametrised, handshaked decode stage for the PRCO core, sitting between fetch and execute. It replaces the single-shot decode pulse with a valid/ready pipeline register, field widths set by parameters, a register scoreboard that stalls RAW/WAW hazards against in-flight writes, a flush input for taken jumps, and a sticky halt on unknown opcodes.

## Interface
- INSTR_W, 16, instruction word width.
- OP_W, 5, opcode field width, at [INSTR_W-1 -: OP_W].
- SEL_W, 3, register select width; fields d, a, b follow the opcode MSB-down (default d=[10:8], a=[7:5], b=[4:2]); constraint OP_W+3*SEL_W <= INSTR_W.
- IMM_W, 8, unsigned immediate width, taken from the instruction LSBs.
- SIMM_W, 5, signed immediate width, taken from the instruction LSBs; constraint IMM_W, SIMM_W <= INSTR_W-OP_W-SEL_W.
- i_clk  in  1  clock; all state on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  fetch presents i_instr.
- i_instr  in  INSTR_W  instruction word.
- o_ready  out  1  decode accepts i_instr this cycle.
- q_valid  out  1  decoded outputs valid.
- i_ready  in  1  execute consumes decoded outputs.
- i_flush  in  1  discard the held instruction and any accept this cycle.
- i_wb_en, i_wb_sel  in  1, SEL_W  register writeback completes; clears a scoreboard bit.
- q_op, q_seld, q_sela, q_selb, q_imm, q_simm  out  OP_W, SEL_W x3, IMM_W, SIMM_W  fields; q_simm is sign-carried.
- q_reg_we, q_req_alu, q_req_ram, q_req_ram_we, q_new_uart1_data, q_halt  out  1 each  control flags.
- o_stall  out  1  hazard blocks the presented instruction.
- o_busy  out  2**SEL_W  scoreboard bits.

## Operation
- Opcodes come from the team ISA include. Flags per op (reg_we/alu/ram/ram_we/uart): NOP 0/0/0/0/0; MOVI 1/1/0/0/0; MOV 1/1/0/0/0; ADD 1/1/0/0/0; ADDI 1/1/0/0/0; LW 1/1/1/0/0; SW 0/1/1/1/0; CMP 0/1/0/0/0; JMP 1/0/0/0/0; WRITE 0/0/0/0/1.
- Sources: MOV a; ADD d,a; ADDI d; LW a; SW d,a; CMP d,a; WRITE d; MOVI, JMP, NOP none. Destination d when reg_we.
- Hazard: a source or destination register has its o_busy bit set (after the same-cycle i_wb clear), or equals q_seld while q_valid & q_reg_we.
- o_stall = i_valid & hazard. o_ready = !i_reset & !q_halt & !hazard & (!q_valid | i_ready).
- Accept (i_valid & o_ready & !i_flush): output register loads all fields and flags; q_valid=1.
- Handshake (q_valid & i_ready & !i_flush) with q_reg_we sets o_busy[q_seld]. i_wb_en clears o_busy[i_wb_sel]. Set and clear to the same register in one cycle: set wins.
- Handshake without accept: q_valid->0. i_flush: q_valid->0, no accept, no scoreboard set; existing o_busy bits are kept.
- Unknown opcode: accepted with all flags 0 and q_halt=1. q_halt is sticky until reset, forcing o_ready=0; q_valid drops after its handshake or a flush.

## Timing
- Reset (async): every q_* output 0, q_valid 0, o_busy 0; o_ready 0 while i_reset is high.
- Latency: accept in cycle N gives q_valid and fields in N+1. Throughput is one per cycle with i_ready held high and no hazards.
- Back-to-back dependency (ADD r1 then ADD r1): the second stalls until the writeback for r1 is seen. With i_wb in cycle M, it accepts in M (clear bypasses the check).
- Reset mid-stall or mid-halt: all state is cleared; the next accept is possible in the first cycle after deassertion.

## Test plan
- Reset, then MOVI d=2 imm=0x5A, i_ready=1 -> next cycle q_valid=1, q_seld=2, q_imm=0x5A, q_reg_we=1, q_req_alu=1; o_busy[2]=1 after the handshake.
- MOVI r3 then ADD d=3 a=1 back-to-back -> o_stall=1 and o_ready=0 until i_wb_en=1, i_wb_sel=3; ADD accepts that same cycle.
- i_ready=0 for 3 cycles with q_valid=1 -> outputs held stable, o_ready=0, no o_busy change; with i_ready=1 the next instruction loads in the same cycle.
- i_flush while holding LW r4 -> q_valid=0 next cycle, o_busy[4] stays 0, an instruction presented that cycle is not accepted.
- Unknown opcode 0x1F -> q_halt=1, all flags 0, o_ready stays 0 for 20 cycles; async reset clears q_halt without a clock edge.
- Handshake of MOV r5 with i_wb_sel=5 in the same cycle -> o_busy[5]=1.
